// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with a grant-hold limit and a one-cycle release turnaround.
// Handshake: req is a level held by a master for as long as it wants the bus; done is a one-cycle slave pulse.
module bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 11
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       done,
    output logic [1:0] grant,
    output logic       msel,
    output logic       bus_busy,
    output logic       timeout,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT0  = 2'd1,
        GRANT1  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic             last;
    logic [CNT_W-1:0] cnt;
    logic             timeout_nxt;
    logic             owner;

    assign owner = (state == GRANT1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            timeout <= 1'b0;
        end else begin
            state   <= state_nxt;
            timeout <= timeout_nxt;
        end
    end

    // last starts at 1 so that master 0 wins the first tie after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last <= 1'b1;
            msel <= 1'b0;
            cnt  <= '0;
        end else if (state == IDLE && (state_nxt == GRANT0 || state_nxt == GRANT1)) begin
            last <= (state_nxt == GRANT1);
            msel <= (state_nxt == GRANT1);
            cnt  <= '0;
        end else if ((state == GRANT0 || state == GRANT1) && state_nxt == state && cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt   = state;
        timeout_nxt = 1'b0;
        case (state)
            IDLE: begin
                case (req)
                    2'b01:   state_nxt = GRANT0;
                    2'b10:   state_nxt = GRANT1;
                    2'b11:   state_nxt = last ? GRANT0 : GRANT1;
                    default: state_nxt = IDLE;
                endcase
            end
            GRANT0, GRANT1: begin
                if (done || !req[owner]) begin
                    state_nxt = RELEASE;
                end else if (cnt == CNT_MAX) begin
                    state_nxt   = RELEASE;
                    timeout_nxt = 1'b1;
                end
            end
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        grant     = 2'b00;
        bus_busy  = 1'b0;
        state_dbg = state;
        case (state)
            GRANT0: begin
                grant    = 2'b01;
                bus_busy = 1'b1;
            end
            GRANT1: begin
                grant    = 2'b10;
                bus_busy = 1'b1;
            end
            RELEASE: bus_busy = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master round-robin arbiter for the shared serial system bus. It sits between the master ports and the slave-side bus multiplexer. It grants the bus to one master at a time and holds the grant until the transaction completes or the master withdraws. A grant that is held too long is forcibly revoked. It drives the master-select used by the bus mux and a busy flag for slave-side logic.

## Interface
- TIMEOUT_CYCLES, 1024: maximum cycles a single grant may be held; legal range 2..2^CNT_W.
- CNT_W, 11: width of the grant-hold counter.
- clk  input  1  bus clock; all state updates on its rising edge.
- reset  input  1  reset, asynchronous, active-high; clock clk.
- req  input  2  per-master bus request; bit i = master i; level-sensitive.
- done  input  1  single-cycle pulse from the slave side marking end of the current transaction (burst included).
- grant  output  2  one-hot grant; 2'b00 when no master owns the bus.
- msel  output  1  mux select: index of the current or most recent grantee. Held stable outside grants.
- bus_busy  output  1  high while any grant is active and during the release turnaround cycle.
- timeout  output  1  single-cycle pulse when a grant is revoked by the hold limit.

## Operation
- Internal state:
  - `state` ∈ {IDLE, GRANT0, GRANT1, RELEASE}.
  - `last` (1 bit): index of the master granted most recently.
  - `cnt` (CNT_W bits): cycles spent in the current grant.
- Reset values (asynchronous, immediate, including mid-transaction):
  - state=IDLE, grant=2'b00, msel=0, bus_busy=0, timeout=0, cnt=0, last=1.
  - last=1 means master 0 wins the first tie.
- IDLE:
  - req=2'b00: stay in IDLE.
  - Exactly one req bit set: go to that master's GRANTi.
  - req=2'b11: go to GRANT for the master ≠ last.
  - On entering GRANTi: last←i, msel←i, cnt←0.
- GRANTi outputs: grant[i]=1, bus_busy=1.
- Each cycle in GRANTi, evaluated in priority order:
  1. done=1 → RELEASE, no timeout.
  2. Else req[i]=0 → RELEASE, no timeout.
  3. Else cnt==TIMEOUT_CYCLES-1 → RELEASE with timeout pulsed for one cycle, coincident with the first RELEASE cycle.
  4. Else stay in GRANTi, cnt←cnt+1.
- Requests from the other master while in GRANTi are ignored; a grant is never preempted.
- RELEASE:
  - grant=2'b00, bus_busy=1, msel unchanged.
  - Unconditionally → IDLE next cycle.
  - This turnaround lets the mux and the slave return to idle.
- done pulses seen in IDLE or RELEASE are ignored.
- grant is never two-hot and never changes without passing through RELEASE.
- cnt saturates at TIMEOUT_CYCLES-1; it never wraps.

## Timing
- All outputs are registered, with no combinational paths from inputs to outputs.
- Request to grant: req sampled high in IDLE at edge N → grant visible after edge N.
  - Minimum latency: 1 cycle.
- Grant end: done or req drop sampled at edge M → grant low after edge M.
  - RELEASE occupies cycle M..M+1.
  - IDLE is reached after edge M+1.
  - Earliest next grant is after edge M+2.
- Back-to-back with req=2'b11 held continuously, the grant sequence is:
  - G0 … RELEASE, IDLE, G1 … RELEASE, IDLE, G0 …
  - Strict alternation.
- Maximum hold: grant stays high for exactly TIMEOUT_CYCLES cycles before forced release.
- done and timeout limit in the same cycle: done wins, timeout stays 0.
- done in the same cycle that req[i] drops: a single normal release.
- reset asserted during GRANT or RELEASE: grant drops asynchronously; no timeout pulse.
- After reset deasserts, the first arbitration occurs on the first clk edge with a req set.

## Test plan
- Single master:
  - Stimulus: reset, then req=2'b01 at edge 2, done pulse at edge 10.
  - Required: grant=01 after edge 2 through edge 10; bus_busy=1 for one extra cycle; msel=0 throughout.
- Tie / round-robin:
  - Stimulus: req=2'b11 held; done pulsed 5 cycles after each grant.
  - Required: first grant to master 0, then master 1, then master 0; grants separated by exactly 2 non-granted cycles; msel tracks the grantee.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=8, req=2'b10 held, no done.
  - Required: grant=10 for exactly 8 cycles; timeout pulse 1 cycle in RELEASE; master 1 regranted after IDLE (sole requester).
- Done vs timeout collision:
  - Stimulus: TIMEOUT_CYCLES=8; done pulsed on the 8th granted cycle.
  - Required: release occurs with timeout=0.
- Request withdrawal and non-preemption:
  - Stimulus: master 0 granted; req[1] rises mid-grant; req[0] drops at edge K.
  - Required: grant never switches directly; grant=00 after edge K; grant=10 after edge K+2.
- Reset mid-grant:
  - Stimulus: assert reset asynchronously between edges during GRANT1.
  - Required: grant=00, msel=0, bus_busy=0 immediately; next tie after reset goes to master 0.
